// File: rtl/dco_tap_ctrl.sv
// rtl/dco_tap_ctrl.sv - ring-oscillator tap-select controller with manual steps and frequency lock
// The auto-lock loop is built only when OSC_LOCK_EN is defined; without it, mode 10 acts as hold.
module dco_tap_ctrl #(
  parameter int TAPS     = 256,
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_res,
  input  logic [1:0]              i_mode,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_dir,
  input  logic [3:0]              i_cmd_step,
  input  logic                    i_ref_tick,
  input  logic [CNT_W-1:0]        i_target,
  input  logic [CNT_W-1:0]        i_tol,
  output logic [$clog2(TAPS)-1:0] o_tap_idx,
  output logic [TAPS-1:0]         o_tap_sel,
  output logic                    o_at_min,
  output logic                    o_at_max,
  output logic [CNT_W-1:0]        o_meas_cnt,
  output logic                    o_meas_valid,
  output logic                    o_locked
);
  localparam int TW = $clog2(TAPS);
  // Wide enough for tap + a 4-bit step without wrapping, even for tiny TAPS.
  localparam int AW = (TW + 1 > 5) ? TW + 1 : 5;

  logic [TW-1:0]   r_tap_idx;
  logic [TAPS-1:0] r_tap_sel;
  logic            r_at_min;
  logic            r_at_max;
  logic [TW-1:0]   w_tap_nxt;
  logic            w_accept;

  function automatic logic [TW-1:0] f_move(input logic [TW-1:0] tap, input logic up,
                                           input logic [3:0] step);
    logic [AW-1:0] t;
    logic [AW-1:0] s;
    logic [AW-1:0] r;
    t = AW'(tap);
    s = AW'(step);
    if (up) begin
      r = t + s;
      if (r > AW'(TAPS - 1)) r = AW'(TAPS - 1);
    end else begin
      r = (s > t) ? '0 : t - s;
    end
    return r[TW-1:0];
  endfunction

  assign o_cmd_ready = (i_mode == 2'b01);
  assign w_accept    = i_cmd_valid && o_cmd_ready;

`ifdef OSC_LOCK_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT_EDGE, S_MEASURE, S_DECIDE} state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_meas_cnt;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_settle;
  logic [3:0]       r_lock_cnt;
  logic             w_auto;
  logic             w_decide;
  logic             w_auto_up;
  logic             w_auto_dn;
  logic [CNT_W-1:0] w_meas;
  logic [CNT_W:0]   w_hi;
  logic [CNT_W:0]   w_lo;

  assign w_auto    = (i_mode == 2'b10);
  assign w_meas    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hi      = {1'b0, i_target} + {1'b0, i_tol};
  assign w_lo      = (i_tol > i_target) ? '0 : {1'b0, i_target - i_tol};
  assign w_decide  = w_auto && (r_state == S_MEASURE) && r_edge && !r_settle;
  assign w_auto_up = w_decide && ({1'b0, w_meas} > w_hi);
  assign w_auto_dn = w_decide && ({1'b0, w_meas} < w_lo);
`endif

  always_comb begin
    w_tap_nxt = r_tap_idx;
    if (w_accept) w_tap_nxt = f_move(r_tap_idx, i_cmd_dir, i_cmd_step);
`ifdef OSC_LOCK_EN
    else if (w_auto_up) w_tap_nxt = f_move(r_tap_idx, 1'b1, 4'd1);
    else if (w_auto_dn) w_tap_nxt = f_move(r_tap_idx, 1'b0, 4'd1);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_tap_idx <= TW'(TAPS - 1);
      r_tap_sel <= {1'b1, {(TAPS-1){1'b0}}};
      r_at_min  <= 1'b0;
      r_at_max  <= 1'b1;
    end else begin
      r_tap_idx <= w_tap_nxt;
      r_tap_sel <= TAPS'(1) << w_tap_nxt;
      r_at_min  <= (w_tap_nxt == '0);
      r_at_max  <= (w_tap_nxt == TW'(TAPS - 1));
    end
  end

`ifdef OSC_LOCK_EN
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_edge       <= 1'b0;
      r_cnt        <= '0;
      r_meas_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_settle     <= 1'b0;
      r_lock_cnt   <= '0;
    end else begin
      r_sync1      <= i_ref_tick;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_edge       <= r_sync2 & ~r_sync3;
      r_meas_valid <= 1'b0;
      if (!w_auto) begin
        r_state    <= S_IDLE;
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
        r_settle   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_EDGE;
          S_WAIT_EDGE: begin
            if (r_edge) begin
              r_state  <= S_MEASURE;
              r_cnt    <= '0;
              r_settle <= 1'b0;
            end
          end
          S_MEASURE: begin
            if (r_edge) begin
              // Publish the measurement and act on it together, at DECIDE entry.
              r_state      <= S_DECIDE;
              r_meas_cnt   <= w_meas;
              r_meas_valid <= 1'b1;
              r_cnt        <= '0;
              if (r_settle) begin
                r_settle <= 1'b0;
              end else if (w_auto_up || w_auto_dn) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
                r_settle   <= (w_tap_nxt != r_tap_idx);
              end else begin
                if (r_lock_cnt < 4'(LOCK_CNT)) r_lock_cnt <= r_lock_cnt + 4'd1;
                r_locked <= (r_lock_cnt >= 4'(LOCK_CNT - 1));
              end
            end else begin
              r_cnt <= w_meas;
            end
          end
          S_DECIDE: begin
            r_state <= S_MEASURE;
            r_cnt   <= w_meas;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_meas_cnt   = r_meas_cnt;
  assign o_meas_valid = r_meas_valid;
  assign o_locked     = r_locked;
`else
  logic w_unused;
  assign w_unused     = ^{i_ref_tick, i_target, i_tol, 4'(LOCK_CNT)};
  assign o_meas_cnt   = '0;
  assign o_meas_valid = 1'b0;
  assign o_locked     = 1'b0;
`endif

  assign o_tap_idx = r_tap_idx;
  assign o_tap_sel = r_tap_sel;
  assign o_at_min  = r_at_min;
  assign o_at_max  = r_at_max;
endmodule

// File: tb/tb_dco_tap_ctrl.sv
// tb/tb_dco_tap_ctrl.sv - scoreboard bench for dco_tap_ctrl with a rule-level lock-loop model
module tb_dco_tap_ctrl;
  localparam int TAPS     = 256;
  localparam int CNT_W    = 16;
  localparam int LOCK_CNT = 4;
`ifdef OSC_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             cmd_valid = 1'b0;
  logic             cmd_dir = 1'b0;
  logic [3:0]       cmd_step = 4'd0;
  logic             ref_tick = 1'b0;
  logic [CNT_W-1:0] target = '0;
  logic [CNT_W-1:0] tol = '0;
  logic             cmd_ready;
  logic [7:0]       tap_idx;
  logic [TAPS-1:0]  tap_sel;
  logic             at_min;
  logic             at_max;
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_valid;
  logic             locked;

  dco_tap_ctrl #(.TAPS(TAPS), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .i_clk(clk), .i_res(res), .i_mode(mode), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_dir(cmd_dir), .i_cmd_step(cmd_step), .i_ref_tick(ref_tick), .i_target(target),
    .i_tol(tol), .o_tap_idx(tap_idx), .o_tap_sel(tap_sel), .o_at_min(at_min), .o_at_max(at_max),
    .o_meas_cnt(meas_cnt), .o_meas_valid(meas_valid), .o_locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct { int cnt; int tap; bit lk; } meas_t;
  meas_t q_meas[$];
  int    q_man[$];
  int    q_per[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    m_tap = TAPS - 1;
  bit    m_locked = 1'b0;
  bit    acc_d = 1'b0;

  function automatic void chk(input string name, input logic [TAPS-1:0] act,
                              input logic [TAPS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT accepts a command or presents a measurement.
  initial begin : monitor
    meas_t e;
    int    t;
    forever begin
      @(negedge clk);
      if (res) begin
        acc_d = 1'b0;
      end else begin
        if (acc_d) begin
          if (q_man.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_accept got accept want none (tap %0d)", tap_idx);
          end else begin
            t = q_man.pop_front();
            chk("man_tap", TAPS'(tap_idx), TAPS'(t));
            chk("man_sel", tap_sel, TAPS'(1) << t);
            chk("man_at_min", TAPS'(at_min), TAPS'(t == 0));
            chk("man_at_max", TAPS'(at_max), TAPS'(t == TAPS - 1));
          end
        end
        if (meas_valid) begin
          if (q_meas.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_meas got cnt %0d want none", meas_cnt);
          end else begin
            e = q_meas.pop_front();
            chk("meas_cnt", TAPS'(meas_cnt), TAPS'(e.cnt));
            chk("auto_tap", TAPS'(tap_idx), TAPS'(e.tap));
            chk("auto_locked", TAPS'(locked), TAPS'(e.lk));
          end
        end
        acc_d = cmd_valid && cmd_ready;
      end
    end
  end

  task automatic chk_reset();
    chk("rst_tap", TAPS'(tap_idx), TAPS'(TAPS - 1));
    chk("rst_sel", tap_sel, TAPS'(1) << (TAPS - 1));
    chk("rst_at_max", TAPS'(at_max), TAPS'(1));
    chk("rst_at_min", TAPS'(at_min), '0);
    chk("rst_meas_cnt", TAPS'(meas_cnt), '0);
    chk("rst_meas_valid", TAPS'(meas_valid), '0);
    chk("rst_locked", TAPS'(locked), '0);
  endtask

  task automatic man_cmd(input bit dir, input int step);
    tick(1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_step  = 4'(step);
    if (mode == 2'b01) begin
      m_tap = dir ? m_tap + step : m_tap - step;
      if (m_tap > TAPS - 1) m_tap = TAPS - 1;
      if (m_tap < 0) m_tap = 0;
      q_man.push_back(m_tap);
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  // Reference model: each period is one measurement; rules applied with plain arithmetic.
  task automatic run_auto(input int tgt, input int tl);
    int    hi;
    int    lo;
    int    lockc;
    int    wait_n;
    bit    settle;
    meas_t e;
    mode     = 2'b00;
    ref_tick = 1'b0;
    target   = CNT_W'(tgt);
    tol      = CNT_W'(tl);
    tick(2);
    mode = 2'b10;
    tick(5);
    lockc    = 0;
    settle   = 1'b0;
    m_locked = 1'b0;
    hi = tgt + tl;
    lo = (tgt > tl) ? tgt - tl : 0;
    if (LOCK_EN) begin
      foreach (q_per[k]) begin
        if (settle) begin
          settle = 1'b0;
        end else if (q_per[k] > hi) begin
          lockc = 0;
          if (m_tap < TAPS - 1) begin m_tap++; settle = 1'b1; end
        end else if (q_per[k] < lo) begin
          lockc = 0;
          if (m_tap > 0) begin m_tap--; settle = 1'b1; end
        end else begin
          lockc++;
        end
        m_locked = (lockc >= LOCK_CNT);
        e.cnt = q_per[k];
        e.tap = m_tap;
        e.lk  = m_locked;
        q_meas.push_back(e);
      end
    end
    ref_tick = 1'b1;
    foreach (q_per[k]) begin
      tick(q_per[k] / 2);
      ref_tick = 1'b0;
      tick(q_per[k] - q_per[k] / 2);
      ref_tick = 1'b1;
    end
    tick(8);
    ref_tick = 1'b0;
    wait_n = 0;
    while (q_meas.size() != 0 && wait_n < 100) begin
      tick(1);
      wait_n++;
    end
    chk("meas_drain", TAPS'(q_meas.size()), '0);
    q_meas.delete();
    chk("run_tap", TAPS'(tap_idx), TAPS'(m_tap));
    chk("run_locked", TAPS'(locked), TAPS'(m_locked));
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tgt;
    int tl;
    int d;
    res = 1'b1;
    tick(2);
    chk_reset();
    res = 1'b0;

    mode = 2'b01;
    repeat (18) man_cmd(1'b0, 15);
    tick(2);
    chk("man_floor_tap", TAPS'(tap_idx), TAPS'(m_tap));
    chk("man_floor_at_min", TAPS'(at_min), TAPS'(m_tap == 0));
    man_cmd(1'b1, 3);

    repeat (24) begin
      if ($urandom_range(0, 9) < 7) mode = 2'b01;
      else mode = 2'($urandom_range(0, 3)) | 2'b00;
      man_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end
    mode = 2'b01;
    tick(2);
    chk("man_rand_tap", TAPS'(tap_idx), TAPS'(m_tap));

    repeat (18) man_cmd(1'b0, 15);
    man_cmd(1'b1, 10);
    q_per = '{120, 120, 120};
    run_auto(100, 2);

    q_per = '{101, 101, 101, 101, 110};
    run_auto(100, 2);

    q_per = '{101, 101, 101, 101};
    run_auto(100, 2);
    mode = 2'b00;
    tick(1);
    chk("locked_after_hold", TAPS'(locked), '0);
    m_locked = 1'b0;

    mode = 2'b01;
    repeat (18) man_cmd(1'b1, 15);
    q_per = '{130, 130, 130, 130};
    run_auto(100, 2);

    repeat (5) begin
      mode = 2'b01;
      repeat (3) man_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      tgt = int'($urandom_range(20, 200));
      tl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 6));
      q_per.delete();
      repeat (6) begin
        d = tgt + int'($urandom_range(0, 24)) - 12;
        q_per.push_back((d < 16) ? 16 : d);
      end
      run_auto(tgt, tl);
    end

    mode = 2'b00;
    tick(2);
    mode = 2'b10;
    tick(5);
    ref_tick = 1'b1;
    tick(10);
    ref_tick = 1'b0;
    tick(45);
    res = 1'b1;
    tick(1);
    chk_reset();
    res      = 1'b0;
    mode     = 2'b00;
    m_tap    = TAPS - 1;
    m_locked = 1'b0;
    tick(4);
    chk("post_reset_tap", TAPS'(tap_idx), TAPS'(m_tap));

    chk("man_queue_left", TAPS'(q_man.size()), '0);
    chk("meas_queue_left", TAPS'(q_meas.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
